// File: rtl/tpu_sched_if.sv
// ID/EX-side TPU control and scheduler-to-array signals. The scheduler takes the slave side.
// The master side is the pipeline/array side.
interface tpu_sched_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              start_i;
    logic              wren_a_i;
    logic              wren_b_i;
    logic              wren_c_i;
    logic [4:0]        row_i;
    logic [4:0]        col_i;
    logic [DATA_W-1:0] data_i;
    logic              tpu_wr_a_o;
    logic              tpu_wr_b_o;
    logic              tpu_wr_c_o;
    logic [4:0]        tpu_row_o;
    logic [4:0]        tpu_col_o;
    logic [DATA_W-1:0] tpu_data_o;
    logic              tpu_run_o;
    logic              done_o;
    logic              busy_o;
    logic              stall_o;
    logic              range_err_o;

    modport master (
        output start_i, wren_a_i, wren_b_i, wren_c_i, row_i, col_i, data_i,
        input  tpu_wr_a_o, tpu_wr_b_o, tpu_wr_c_o, tpu_row_o, tpu_col_o, tpu_data_o,
        input  tpu_run_o, done_o, busy_o, stall_o, range_err_o
    );

    modport slave (
        input  start_i, wren_a_i, wren_b_i, wren_c_i, row_i, col_i, data_i,
        output tpu_wr_a_o, tpu_wr_b_o, tpu_wr_c_o, tpu_row_o, tpu_col_o, tpu_data_o,
        output tpu_run_o, done_o, busy_o, stall_o, range_err_o
    );
endinterface

// File: rtl/tpu_sched.sv
// Purpose: sequences the systolic TPU: forwards A/B/C writes, runs a RUN_CYC-cycle compute window per start.
// Latency: writes reach the array 1 cycle after acceptance; run T+1..T+RUN_CYC, done at T+RUN_CYC+1.
// Backpressure: stall_o holds any TPU op while busy. Optional TPU_PERF_CNT_EN adds perf_cnt_o.
module tpu_sched #(
    parameter int unsigned DIM     = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RUN_CYC = 3*DIM-2
) (
    input  logic        clk_i,
    input  logic        rst_i,
`ifdef TPU_PERF_CNT_EN
    output logic [31:0] perf_cnt_o,
`endif
    tpu_sched_if.slave  bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int unsigned      CNT_W    = (RUN_CYC > 1) ? $clog2(RUN_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RUN_CYC - 1);

    logic [1:0]       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             op;
    logic             idle;
    logic             accept;
    logic             wr_any;
    logic             idx_ok;

    assign op     = bus.start_i | bus.wren_a_i | bus.wren_b_i | bus.wren_c_i;
    assign wr_any = bus.wren_a_i | bus.wren_b_i | bus.wren_c_i;
    assign idle   = (state_q == ST_IDLE);
    assign accept = op & idle;
    assign idx_ok = (32'(bus.row_i) < DIM) && (32'(bus.col_i) < DIM);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && bus.start_i) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    // Counter stops at its last value rather than wrapping.
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus.tpu_wr_a_o  <= 1'b0;
            bus.tpu_wr_b_o  <= 1'b0;
            bus.tpu_wr_c_o  <= 1'b0;
            bus.tpu_row_o   <= '0;
            bus.tpu_col_o   <= '0;
            bus.tpu_data_o  <= '0;
            bus.range_err_o <= 1'b0;
        end else begin
            bus.tpu_wr_a_o <= accept & bus.wren_a_i & idx_ok;
            bus.tpu_wr_b_o <= accept & bus.wren_b_i & idx_ok;
            bus.tpu_wr_c_o <= accept & bus.wren_c_i & idx_ok;
            if (accept) begin
                bus.tpu_row_o  <= bus.row_i;
                bus.tpu_col_o  <= bus.col_i;
                bus.tpu_data_o <= bus.data_i;
            end
            // Sticky until reset so software can detect any dropped write.
            if (accept && wr_any && !idx_ok) begin
                bus.range_err_o <= 1'b1;
            end
        end
    end

    assign bus.tpu_run_o = (state_q == ST_RUN);
    assign bus.done_o    = (state_q == ST_DONE);
    assign bus.busy_o    = ~idle;
    assign bus.stall_o   = op & ~idle;

`ifdef TPU_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cnt_o <= '0;
        end else if ((bus.busy_o || bus.stall_o) && (perf_cnt_o != 32'hFFFF_FFFF)) begin
            perf_cnt_o <= perf_cnt_o + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tpu_sched.sv
// Scoreboarded bench for tpu_sched: directed scenarios plus random op streams against a cycle-window model.
module tb_tpu_sched;
    localparam int DIM     = 8;
    localparam int DATA_W  = 32;
    localparam int RUN_CYC = 22;
    localparam int NEVER   = 32'h7fff_ffff;

    typedef struct {
        int          c;
        logic [2:0]  w;
        logic [4:0]  r;
        logic [4:0]  cl;
        logic [31:0] d;
    } wr_ev_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Model state: the current compute window, pending events, sticky error onset, busy-cycle tally.
    int     run_lo = 1;
    int     run_hi = -1;
    int     err_from = NEVER;
    int     model_perf = 0;
    wr_ev_t wr_q[$];
    int     done_q[$];

    tpu_sched_if #(.DATA_W(DATA_W)) bus ();
`ifdef TPU_PERF_CNT_EN
    logic [31:0] perf_cnt;
`endif

    tpu_sched #(.DIM(DIM), .DATA_W(DATA_W), .RUN_CYC(RUN_CYC)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
`ifdef TPU_PERF_CNT_EN
        .perf_cnt_o (perf_cnt),
`endif
        .bus        (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: act=%0h req=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit busy_at(input int c);
        return (c >= run_lo) && (c <= run_hi + 1);
    endfunction

    task automatic model_reset();
        run_lo = 1;
        run_hi = -1;
        err_from = NEVER;
        model_perf = 0;
        wr_q.delete();
        done_q.delete();
    endtask

    task automatic clear_inputs();
        bus.start_i  = 1'b0;
        bus.wren_a_i = 1'b0;
        bus.wren_b_i = 1'b0;
        bus.wren_c_i = 1'b0;
        bus.row_i    = '0;
        bus.col_i    = '0;
        bus.data_i   = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // Called 1 time unit after a rising edge; holds the op until the model says it is accepted.
    task automatic issue(input bit s, input bit [2:0] w, input bit [4:0] r, input bit [4:0] c,
                         input bit [31:0] d);
        int guard;
        guard = 0;
        bus.start_i  = s;
        bus.wren_a_i = w[0];
        bus.wren_b_i = w[1];
        bus.wren_c_i = w[2];
        bus.row_i    = r;
        bus.col_i    = c;
        bus.data_i   = d;
        while (busy_at(cyc) && guard <= 4*RUN_CYC) begin
            @(posedge clk_i);
            #1;
            guard++;
        end
        if (guard > 4*RUN_CYC) begin
            checks++;
            errors++;
            $display("FAIL accept_bound: act=waited %0d cycles req=<= %0d", guard, 4*RUN_CYC);
        end
        if (w != 3'b000) begin
            if (int'(r) < DIM && int'(c) < DIM) wr_q.push_back('{cyc + 1, w, r, c, d});
            else if (err_from > cyc + 1) err_from = cyc + 1;
        end
        if (s) begin
            run_lo = cyc + 1;
            run_hi = cyc + RUN_CYC;
            done_q.push_back(cyc + RUN_CYC + 1);
        end
        @(posedge clk_i);
        #1;
        clear_inputs();
    endtask

    task automatic pulse_reset();
        rst_i = 1'b1;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
    endtask

    always @(negedge clk_i) begin : monitor
        bit       bz;
        bit       opv;
        wr_ev_t   e;
        int       dc;
        bz  = busy_at(cyc);
        opv = bus.start_i | bus.wren_a_i | bus.wren_b_i | bus.wren_c_i;
        check("run", 64'(bus.tpu_run_o), 64'(cyc >= run_lo && cyc <= run_hi));
        check("busy", 64'(bus.busy_o), 64'(bz));
        check("stall", 64'(bus.stall_o), 64'(opv && bz));
        check("range_err", 64'(bus.range_err_o), 64'(cyc >= err_from));
        while (wr_q.size() > 0 && wr_q[0].c < cyc) begin
            e = wr_q.pop_front();
            check("wr_missing", 64'(0), 64'(e.c));
        end
        if (bus.tpu_wr_a_o || bus.tpu_wr_b_o || bus.tpu_wr_c_o) begin
            if (wr_q.size() == 0) begin
                check("wr_unexpected", 64'({bus.tpu_wr_c_o, bus.tpu_wr_b_o, bus.tpu_wr_a_o}), 64'(0));
            end else begin
                e = wr_q.pop_front();
                check("wr_cycle", 64'(cyc), 64'(e.c));
                check("wr_bits", 64'({bus.tpu_wr_c_o, bus.tpu_wr_b_o, bus.tpu_wr_a_o}), 64'(e.w));
                check("wr_row", 64'(bus.tpu_row_o), 64'(e.r));
                check("wr_col", 64'(bus.tpu_col_o), 64'(e.cl));
                check("wr_data", 64'(bus.tpu_data_o), 64'(e.d));
            end
        end
        while (done_q.size() > 0 && done_q[0] < cyc) begin
            dc = done_q.pop_front();
            check("done_missing", 64'(0), 64'(dc));
        end
        if (bus.done_o) begin
            if (done_q.size() == 0) begin
                check("done_unexpected", 64'(cyc), 64'(0));
            end else begin
                dc = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(dc));
            end
        end
`ifdef TPU_PERF_CNT_EN
        check("perf_cnt", 64'(perf_cnt), 64'(model_perf));
`endif
        if (bz) model_perf++;
    end

    initial begin
        bit          s;
        bit [2:0]    w;
        bit [4:0]    r;
        bit [4:0]    c;
        clear_inputs();
        @(posedge clk_i);
        #1;
        check("rst_wr_a", 64'(bus.tpu_wr_a_o), 64'(0));
        check("rst_row", 64'(bus.tpu_row_o), 64'(0));
        check("rst_data", 64'(bus.tpu_data_o), 64'(0));
        check("rst_range_err", 64'(bus.range_err_o), 64'(0));
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // Single in-range write, then a start, then a write held behind the run.
        issue(1'b0, 3'b001, 5'd2, 5'd3, 32'hDEAD_BEEF);
        idle(3);
        issue(1'b1, 3'b000, 5'd0, 5'd0, 32'h0);
        idle(4);
        issue(1'b0, 3'b010, 5'd1, 5'd1, 32'h0000_1234);

        // Out-of-range write; the error must survive a later start/done.
        issue(1'b0, 3'b100, 5'd8, 5'd0, 32'h0000_0055);
        issue(1'b0, 3'b001, 5'd7, 5'd7, 32'h0000_0077);
        issue(1'b1, 3'b000, 5'd0, 5'd0, 32'h0);
        idle(RUN_CYC + 3);

        // Asynchronous reset at run cycle 5 with an op held upstream.
        issue(1'b1, 3'b000, 5'd0, 5'd0, 32'h0);
        idle(4);
        bus.wren_b_i = 1'b1;
        #1;
        check("stall_before_rst", 64'(bus.stall_o), 64'(1));
        rst_i = 1'b1;
        model_reset();
        #1;
        check("async_run", 64'(bus.tpu_run_o), 64'(0));
        check("async_busy", 64'(bus.busy_o), 64'(0));
        check("async_stall", 64'(bus.stall_o), 64'(0));
        bus.wren_b_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        issue(1'b1, 3'b000, 5'd0, 5'd0, 32'h0);
        idle(RUN_CYC + 2);

        // Start together with a write, from a fresh reset.
        pulse_reset();
        issue(1'b1, 3'b001, 5'd0, 5'd0, 32'hA5A5_5A5A);
        idle(RUN_CYC + 1);
`ifdef TPU_PERF_CNT_EN
        check("perf_after_done", 64'(perf_cnt), 64'(RUN_CYC + 1));
`endif

        // Random op stream.
        for (int i = 0; i < 160; i++) begin
            s = ($urandom_range(0, 3) == 0);
            w = s ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 7));
            r = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            c = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            issue(s, w, r, c, $urandom);
            idle($urandom_range(0, 3));
            if (i == 80) pulse_reset();
        end

        idle(RUN_CYC + 4);
        check("wr_q_drained", 64'(wr_q.size()), 64'(0));
        check("done_q_drained", 64'(done_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
